seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath's single-cycle ALU.
- Single-cycle ops keep the existing 4-bit ALUControl encoding; results are now registered.
- Multiply and divide run as iterative shift-add and restoring-divide engines, giving full double-width product and remainder.
- Sits in the multi-cycle CPU execute stage. The control FSM issues start, waits for done, then samples result, result_hi and flags.

Parameters:
- WIDTH, 32, operand and result width; legal values ≥ 4.
- SHAMT_W, $clog2(WIDTH), number of srca LSBs used as the shift amount.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  issue request; sampled only while busy=0.
- alu_control  input  4  operation code, captured at start.
- srca  input  WIDTH  operand A, captured at start.
- srcb  input  WIDTH  operand B, captured at start.
- busy  output  1  high while a multi-cycle op is in progress.
- done  output  1  one-cycle pulse when result, result_hi and flags are valid.
- result  output  WIDTH  primary result; holds until the next completion.
- result_hi  output  WIDTH  product high half or division remainder; 0 for other ops.
- zero  output  1  high when captured srca == captured srcb (branch compare).
- div_by_zero  output  1  high when a divide completed with srcb == 0.
- illegal_op  output  1  high when the completed op was an unused code.

Behaviour:
- Reset (async, any state): state returns to IDLE. busy, done, result, result_hi, zero, div_by_zero and illegal_op all go to 0. Any in-flight op is discarded and produces no done.
- States:
  - IDLE: waits for start.
  - MUL, DIV: iterate, one step per clock.
  - Multi-cycle ops return to IDLE on the final step.
- Start accepted at edge k (state IDLE):
  - Operands and opcode are captured.
  - zero, div_by_zero and illegal_op are updated with the final result, not at capture.
- Single-cycle ops (complete at edge k, done=1 during cycle k+1, busy never asserted):
  - 0000 add, 0001 sub: modulo 2^WIDTH.
  - 0100 xor, 0101 and, 0110 or, 0111 not srca, 1000 nor.
  - 1001 set-less-than unsigned; 1101 set-less-than signed. Result is 1 or 0.
  - 1010 sll, 1011 srl, 1100 sra: shift srcb by srca[SHAMT_W-1:0]. sra is sign-filling.
  - 1110, 1111: result=0, illegal_op=1.
  - All of these set result_hi=0.
- 0010 multiply (unsigned):
  - busy=1 from cycle k+1.
  - WIDTH shift-add iterations at edges k+1..k+WIDTH.
  - At edge k+WIDTH: result = low half, result_hi = high half, busy=0, done=1 in cycle k+WIDTH+1.
- 0011 divide (unsigned restoring):
  - Same timing as multiply. result = quotient, result_hi = remainder.
  - srcb==0: completes as a single-cycle op. result = all ones, result_hi = srca, div_by_zero=1.
- div_by_zero and illegal_op are cleared by any completion that does not set them.
- start while busy=1 is ignored. No queueing, no error flag.
- Back-to-back issue: start may be asserted in the cycle where done=1. It is accepted, since busy=0 there.
- Operand and opcode changes after capture have no effect on the op in flight.
- result and flags change only at completion edges or reset.

Test Plan:
- Reset mid-operation: assert rst during MUL iteration 5 → busy, done and outputs 0 immediately (async); no done pulse follows; next start works normally.
- Single-cycle ops, WIDTH=32:
  - add 0xFFFFFFFF+1 → result 0, zero=0, done one cycle after start.
  - sub 5-5 → result 0, zero=1.
  - sra 0x80000000 by 4 → 0xF8000000.
  - slt signed -1<1 → 1; slt unsigned 0xFFFFFFFF<1 → 0.
- Multiply 0xFFFFFFFF*0xFFFFFFFF → result 0x00000001, result_hi 0xFFFFFFFE, busy for exactly 32 cycles, done in cycle k+33.
- Divide:
  - 100/7 → result 14, result_hi 2, div_by_zero=0.
  - 9/0 → result 0xFFFFFFFF, result_hi 9, div_by_zero=1, done one cycle after start.
- Handshake:
  - start pulsed during a DIV → ignored; the original quotient is delivered.
  - start in the done cycle with op add 2+3 → result 5 one cycle later.
- Illegal op 1111 → result 0, illegal_op=1; the following add clears illegal_op. Repeat the full suite with WIDTH=8 (mul 0xFF*0xFF → 0x01/0xFE, 8-cycle latency).

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with registered single-cycle ops and iterative
// shift-add multiply / restoring divide giving double-width results.
module seq_alu #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             div_by_zero,
   output logic             illegal_op
);
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] a, b, hi, lo, sc_res, mul_hi, mul_lo, div_hi, div_lo, d;
   logic [WIDTH:0] sum, sh;
   logic [SHAMT_W-1:0] cnt, shamt;
   logic ge, is_mul, is_div, last;
   assign shamt  = srca[SHAMT_W-1:0];
   assign is_mul = alu_control == 4'b0010;
   assign is_div = alu_control == 4'b0011 && srcb != '0;
   assign last   = cnt == '0;
   assign busy   = state != IDLE;
   // one shift-add step: {hi,lo} holds partial product over the remaining multiplier bits
   assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
   assign mul_hi = sum[WIDTH:1];
   assign mul_lo = {sum[0], lo[WIDTH-1:1]};
   // one restoring step: hi is the running remainder, lo shifts dividend out and quotient in;
   // when ge the true difference is below b, so the low WIDTH bits suffice
   assign sh     = {hi, lo[WIDTH-1]};
   assign ge     = sh >= {1'b0, b};
   assign d      = sh[WIDTH-1:0] - b;
   assign div_hi = ge ? d : sh[WIDTH-1:0];
   assign div_lo = {lo[WIDTH-2:0], ge};
   always_comb begin
      sc_res = '0;
      case (alu_control)
         4'b0000: sc_res = srca + srcb;
         4'b0001: sc_res = srca - srcb;
         4'b0011: sc_res = '1;
         4'b0100: sc_res = srca ^ srcb;
         4'b0101: sc_res = srca & srcb;
         4'b0110: sc_res = srca | srcb;
         4'b0111: sc_res = ~srca;
         4'b1000: sc_res = ~(srca | srcb);
         4'b1001: sc_res = WIDTH'(srca < srcb);
         4'b1010: sc_res = srcb << shamt;
         4'b1011: sc_res = srcb >> shamt;
         4'b1100: sc_res = $signed(srcb) >>> shamt;
         4'b1101: sc_res = WIDTH'($signed(srca) < $signed(srcb));
         default: sc_res = '0;
      endcase
   end
   always_comb begin
      state_n = state;
      state_n = state == IDLE ? (!start ? IDLE : is_mul ? MUL : is_div ? DIV : IDLE)
                              : (last ? IDLE : state);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a           <= '0;
         b           <= '0;
         hi          <= '0;
         lo          <= '0;
         cnt         <= '0;
         done        <= 1'b0;
         result      <= '0;
         result_hi   <= '0;
         zero        <= 1'b0;
         div_by_zero <= 1'b0;
         illegal_op  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) begin
            a   <= srca;
            b   <= srcb;
            hi  <= '0;
            lo  <= is_div ? srca : srcb;
            cnt <= SHAMT_W'(WIDTH-1);
            if (!is_mul && !is_div) begin
               result      <= sc_res;
               result_hi   <= alu_control == 4'b0011 ? srca : '0;
               zero        <= srca == srcb;
               div_by_zero <= alu_control == 4'b0011;
               illegal_op  <= &alu_control[3:1];
               done        <= 1'b1;
            end
         end else if (state != IDLE) begin
            hi  <= state == MUL ? mul_hi : div_hi;
            lo  <= state == MUL ? mul_lo : div_lo;
            cnt <= cnt - SHAMT_W'(1);
            if (last) begin
               result      <= state == MUL ? mul_lo : div_lo;
               result_hi   <= state == MUL ? mul_hi : div_hi;
               zero        <= a == b;
               div_by_zero <= 1'b0;
               illegal_op  <= 1'b0;
               done        <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu at WIDTH=32 and WIDTH=8, one DUT selected at a time.
module tb_seq_alu;
   logic clk, rst, start, sel8;
   logic [3:0] alu_control;
   logic [31:0] srca, srcb;
   logic busy32, done32, zero32, dbz32, ill32;
   logic busy8, done8, zero8, dbz8, ill8;
   logic [31:0] res32, hi32;
   logic [7:0] res8, hi8;
   logic busy_o, done_o, zero_o, dbz_o, ill_o;
   logic [31:0] res_o, hi_o, m;
   int w, total, bad;

   seq_alu #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .start(start & ~sel8), .alu_control(alu_control),
      .srca(srca), .srcb(srcb), .busy(busy32), .done(done32), .result(res32), .result_hi(hi32),
      .zero(zero32), .div_by_zero(dbz32), .illegal_op(ill32));
   seq_alu #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start & sel8), .alu_control(alu_control),
      .srca(srca[7:0]), .srcb(srcb[7:0]), .busy(busy8), .done(done8), .result(res8), .result_hi(hi8),
      .zero(zero8), .div_by_zero(dbz8), .illegal_op(ill8));

   assign busy_o = sel8 ? busy8 : busy32;
   assign done_o = sel8 ? done8 : done32;
   assign zero_o = sel8 ? zero8 : zero32;
   assign dbz_o  = sel8 ? dbz8  : dbz32;
   assign ill_o  = sel8 ? ill8  : ill32;
   assign res_o  = sel8 ? {24'h0, res8} : res32;
   assign hi_o   = sel8 ? {24'h0, hi8}  : hi32;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL w%0d %s got=%h exp=%h", w, tag, got, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      start = 1; alu_control = op; srca = x; srcb = y;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done(output int lat, output int bc);
      lat = 1; bc = 0;
      while (!done_o && lat < 200) begin
         bc += int'(busy_o);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] er, input logic [31:0] eh, input int elat);
      int lat, bc;
      issue(op, x, y);
      wait_done(lat, bc);
      chk({tag, ".res"}, res_o, er);
      chk({tag, ".hi"}, hi_o, eh);
      chk({tag, ".lat"}, 32'(lat), 32'(elat));
      if (elat > 1) begin
         chk({tag, ".busycyc"}, 32'(bc), 32'(elat - 1));
         chk({tag, ".busy_at_done"}, {31'h0, busy_o}, 0);
      end
   endtask

   task automatic suite;
      int lat, bc, nd;
      rst = 1;
      @(negedge clk);
      chk("reset.ctl", {27'h0, busy_o, done_o, zero_o, dbz_o, ill_o}, 0);
      chk("reset.res", res_o, 0);
      chk("reset.hi", hi_o, 0);
      rst = 0;
      @(negedge clk);
      run("add_wrap", 4'b0000, m, 1, 0, 0, 1);
      chk("add_wrap.zero", {31'h0, zero_o}, 0);
      run("sub", 4'b0001, 5, 5, 0, 0, 1);
      chk("sub.zero", {31'h0, zero_o}, 1);
      run("xor", 4'b0100, 'hC, 'hA, 6, 0, 1);
      @(negedge clk);
      chk("hold.done", {31'h0, done_o}, 0);
      chk("hold.res", res_o, 6);
      run("and", 4'b0101, 'hC, 'hA, 8, 0, 1);
      run("or", 4'b0110, 'hC, 'hA, 'hE, 0, 1);
      run("not", 4'b0111, 'h0F, 'hA, m ^ 'hF, 0, 1);
      run("nor", 4'b1000, 'hC, 'hA, m ^ 'hE, 0, 1);
      run("sll", 4'b1010, 3, 1, 8, 0, 1);
      run("srl", 4'b1011, 1, 'h80, 'h40, 0, 1);
      run("sra_neg", 4'b1100, 4, (w == 32) ? 32'h80000000 : 32'h80, (w == 32) ? 32'hF8000000 : 32'hF8, 0, 1);
      run("sra_pos", 4'b1100, 4, 'h40, 'h04, 0, 1);
      run("slt_s", 4'b1101, m, 1, 1, 0, 1);
      run("slt_u", 4'b1001, m, 1, 0, 0, 1);
      run("slt_u2", 4'b1001, 1, m, 1, 0, 1);
      run("mul_max", 4'b0010, m, m, 1, m - 1, w + 1);
      run("b2b_add", 4'b0000, 2, 3, 5, 0, 1);
      run("mul_small", 4'b0010, 13, 11, 143, 0, w + 1);
      run("div", 4'b0011, 100, 7, 14, 2, w + 1);
      chk("div.dbz", {31'h0, dbz_o}, 0);
      run("div2", 4'b0011, 200, 13, 15, 5, w + 1);
      run("div0", 4'b0011, 9, 0, m, 9, 1);
      chk("div0.dbz", {31'h0, dbz_o}, 1);
      run("dbz_clr", 4'b0000, 1, 1, 2, 0, 1);
      chk("dbz_clr.dbz", {31'h0, dbz_o}, 0);
      issue(4'b0011, 100, 7);
      repeat (3) @(negedge clk);
      start = 1; alu_control = 4'b0000; srca = 1; srcb = 1;
      @(negedge clk);
      start = 0;
      wait_done(lat, bc);
      chk("ign.res", res_o, 14);
      chk("ign.hi", hi_o, 2);
      chk("ign.lat", 32'(lat + 4), 32'(w + 1));
      run("ill", 4'b1111, 3, 4, 0, 0, 1);
      chk("ill.flag", {31'h0, ill_o}, 1);
      run("ill_clr", 4'b0000, 2, 2, 4, 0, 1);
      chk("ill_clr.flag", {31'h0, ill_o}, 0);
      chk("ill_clr.zero", {31'h0, zero_o}, 1);
      run("pre", 4'b0000, 7, 1, 8, 0, 1);
      issue(4'b0010, m, m);
      repeat (4) @(negedge clk);
      #2 rst = 1;
      #1;
      chk("midrst.busy", {31'h0, busy_o}, 0);
      chk("midrst.done", {31'h0, done_o}, 0);
      chk("midrst.res", res_o, 0);
      chk("midrst.hi", hi_o, 0);
      @(negedge clk);
      rst = 0;
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         nd += int'(done_o);
      end
      chk("midrst.nodone", 32'(nd), 0);
      run("post", 4'b0000, 2, 3, 5, 0, 1);
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1; start = 0; alu_control = 0; srca = 0; srcb = 0; sel8 = 0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel8 = s[0];
         w = s == 0 ? 32 : 8;
         m = s == 0 ? 32'hFFFFFFFF : 32'hFF;
         suite();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
